// File: rtl/au_add_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// au_add_pipe : segmented pipelined add/subtract unit with prefix-tree segments
// Rev 1.0     : initial release
// ============================================================================
module au_add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int ARCH   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int SEG    = WIDTH / STAGES;
    localparam int LAST_W = WIDTH - (STAGES - 1) * SEG;

    logic             adv;
    logic             out_valid_q, co_q, ov_q;
    logic [WIDTH-1:0] s_q;
    logic             out_valid_d, co_d, ov_d;
    logic [WIDTH-1:0] s_d;

    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO     = k * SEG;
        localparam int SW     = (k == STAGES - 1) ? LAST_W : SEG;
        localparam int HI     = LO + SW;
        localparam int BK_TOP = (SW > 1) ? (1 << ($clog2(SW) - 1)) : 1;

        logic [WIDTH-1:LO] a_x, b_x;
        logic [HI-1:0]     sum_x;
        logic              c_x, v_x;
        logic [SW-1:0]     seg_s;
        logic              seg_co;

        if (k == 0) begin : g_in
            assign a_x   = a;
            assign b_x   = sub ? ~b : b;
            assign c_x   = ci ^ sub;
            assign v_x   = in_valid;
            assign sum_x = seg_s;
        end else begin : g_reg
            // Upper operand bits ride along (skew); finished low sum bits wait (deskew).
            logic [WIDTH-1:LO] a_q, b_q;
            logic [LO-1:0]     lo_q;
            logic              c_q, v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    lo_q <= '0;
                    c_q  <= 1'b0;
                    v_q  <= 1'b0;
                end else if (adv) begin
                    a_q  <= g_stage[k-1].a_x[WIDTH-1:LO];
                    b_q  <= g_stage[k-1].b_x[WIDTH-1:LO];
                    lo_q <= g_stage[k-1].sum_x;
                    c_q  <= g_stage[k-1].seg_co;
                    v_q  <= g_stage[k-1].v_x;
                end
            end

            assign a_x   = a_q;
            assign b_x   = b_q;
            assign c_x   = c_q;
            assign v_x   = v_q;
            assign sum_x = {seg_s, lo_q};
        end

        logic [SW-1:0] pg_p0, pg_g, pg_p, pg_gn, pg_pn;
        logic [SW:0]   pg_c;

        // Carry-in folded into bit 0 generate, so group generates are the carries.
        always_comb begin
            pg_p0   = a_x[HI-1:LO] ^ b_x[HI-1:LO];
            pg_g    = a_x[HI-1:LO] & b_x[HI-1:LO];
            pg_p    = pg_p0;
            pg_gn   = '0;
            pg_pn   = '0;
            pg_g[0] = pg_g[0] | (pg_p0[0] & c_x);
            if (ARCH == 0) begin
                for (int d = 1; d < SW; d = d * 2) begin
                    pg_gn = pg_g;
                    pg_pn = pg_p;
                    for (int i = d; i < SW; i++) begin
                        pg_gn[i] = pg_g[i] | (pg_p[i] & pg_g[i-d]);
                        pg_pn[i] = pg_p[i] & pg_p[i-d];
                    end
                    pg_g = pg_gn;
                    pg_p = pg_pn;
                end
            end else if (ARCH == 1) begin
                for (int d = 1; d < SW; d = d * 2) begin
                    for (int i = 0; i < SW; i++) begin
                        if ((i & d) != 0) begin
                            pg_g[i] = pg_g[i] | (pg_p[i] & pg_g[(i / (2 * d)) * 2 * d + d - 1]);
                            pg_p[i] = pg_p[i] & pg_p[(i / (2 * d)) * 2 * d + d - 1];
                        end
                    end
                end
            end else begin
                for (int d = 1; d < SW; d = d * 2) begin
                    for (int i = 2 * d - 1; i < SW; i = i + 2 * d) begin
                        pg_g[i] = pg_g[i] | (pg_p[i] & pg_g[i-d]);
                        pg_p[i] = pg_p[i] & pg_p[i-d];
                    end
                end
                for (int d = BK_TOP; d >= 1; d = d / 2) begin
                    for (int i = 3 * d - 1; i < SW; i = i + 2 * d) begin
                        pg_g[i] = pg_g[i] | (pg_p[i] & pg_g[i-d]);
                        pg_p[i] = pg_p[i] & pg_p[i-d];
                    end
                end
            end
            pg_c   = {pg_g, c_x};
            seg_s  = pg_p0 ^ pg_c[SW-1:0];
            seg_co = pg_c[SW];
        end
    end

    // Carry into the MSB is recovered as s^a^b' at the top bit.
    assign s_d         = g_stage[STAGES-1].sum_x;
    assign co_d        = g_stage[STAGES-1].seg_co;
    assign ov_d        = s_d[WIDTH-1] ^ g_stage[STAGES-1].a_x[WIDTH-1]
                       ^ g_stage[STAGES-1].b_x[WIDTH-1] ^ co_d;
    assign out_valid_d = g_stage[STAGES-1].v_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            co_q        <= 1'b0;
            ov_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            s_q         <= s_d;
            co_q        <= co_d;
            ov_q        <= ov_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign co        = co_q;
    assign ov        = ov_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_au_add_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for au_add_pipe: directed cases on an 8-bit/2-stage instance plus a
// randomized stream shared by several configurations, each with its own scoreboard.
module tb_au_add_pipe;
    localparam int NDUT = 7;
    localparam int CFG_W [NDUT] = '{8, 13, 13, 1, 8, 13, 8};
    localparam int CFG_S [NDUT] = '{2, 3, 13, 1, 8, 1, 3};
    localparam int CFG_A [NDUT] = '{0, 1, 2, 0, 1, 2, 2};

    logic        clk;
    logic        rst_n;
    logic        r_vld, r_ci, r_sub, r_ordy;
    logic [15:0] r_a, r_b;
    logic [NDUT-1:0] w_busy;
    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands; returns {co, ov, s[15:0]}.
    function automatic logic [31:0] ref_add(input int n, input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic sb);
        int m, ux, uy, ec, u, sx, sy, ss;
        logic ovf, cof;
        m  = 1 << n;
        ux = int'(x) & (m - 1);
        uy = int'(y) & (m - 1);
        if (sb) uy = (~uy) & (m - 1);
        ec  = (c ^ sb) ? 1 : 0;
        u   = ux + uy + ec;
        cof = (u >= m);
        sx  = (ux >= m / 2) ? ux - m : ux;
        sy  = (uy >= m / 2) ? uy - m : uy;
        ss  = sx + sy + ec;
        ovf = (ss >= m / 2) || (ss < -(m / 2));
        return {14'b0, cof, ovf, 16'(u & (m - 1))};
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int W = CFG_W[gi];
        logic [W-1:0] d_a, d_b, d_s;
        logic         d_irdy, d_ovld, d_co, d_ov;
        logic [31:0]  exp_q [$];
        logic [31:0]  e;
        logic         busy = 1'b0;

        assign d_a = r_a[W-1:0];
        assign d_b = r_b[W-1:0];
        assign w_busy[gi] = busy;

        au_add_pipe #(.WIDTH(W), .STAGES(CFG_S[gi]), .ARCH(CFG_A[gi])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (r_vld),
            .in_ready (d_irdy),
            .a        (d_a),
            .b        (d_b),
            .ci       (r_ci),
            .sub      (r_sub),
            .out_valid(d_ovld),
            .out_ready(r_ordy),
            .s        (d_s),
            .co       (d_co),
            .ov       (d_ov)
        );

        // Handshakes seen here complete at the following rising edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (d_ovld && r_ordy) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("u%0d_unexpected_out", gi), 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("u%0d_result", gi), {14'b0, d_co, d_ov, 16'(d_s)}, e);
                    end
                end
                if (r_vld && d_irdy) exp_q.push_back(ref_add(W, r_a, r_b, r_ci, r_sub));
            end
            busy = (exp_q.size() != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic sb);
        r_vld = v;
        r_a   = x;
        r_b   = y;
        r_ci  = c;
        r_sub = sb;
    endtask

    task automatic chk0(input string tag, input logic v, input logic c, input logic o,
                        input logic [7:0] sv);
        chk(tag, {21'b0, g_dut[0].d_ovld, g_dut[0].d_co, g_dut[0].d_ov, g_dut[0].d_s},
                 {21'b0, v, c, o, sv});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e0, e1, e2;
        rst_n  = 1'b0;
        r_ordy = 1'b1;
        put(0, 16'h0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk0("reset_outputs", 0, 0, 0, 8'h00);
        chk("reset_in_ready", 32'(g_dut[0].d_irdy), 32'd1);
        rst_n = 1'b1;
        tick();

        // Carry across the segment boundary.
        put(1, 16'h00FF, 16'h0001, 0, 0);
        tick();
        put(0, 16'h0, 16'h0, 0, 0);
        chk0("ff_plus_1_not_yet", 0, g_dut[0].d_co, g_dut[0].d_ov, g_dut[0].d_s);
        tick();
        chk0("ff_plus_1", 1, 1, 0, 8'h00);

        // Signed overflow on add; subtraction with borrow.
        put(1, 16'h007F, 16'h0001, 0, 0);
        tick();
        put(1, 16'h0005, 16'h0007, 0, 1);
        tick();
        chk0("7f_plus_1", 1, 0, 1, 8'h80);
        put(0, 16'h0, 16'h0, 0, 0);
        tick();
        chk0("5_minus_7", 1, 0, 0, 8'hFE);
        repeat (3) tick();

        // Back-to-back stream with a 3-cycle consumer stall.
        e0 = ref_add(8, 16'h12, 16'h34, 0, 0);
        e1 = ref_add(8, 16'hF0, 16'h20, 1, 0);
        e2 = ref_add(8, 16'h80, 16'h01, 0, 1);
        put(1, 16'h12, 16'h34, 0, 0);
        tick();
        put(1, 16'hF0, 16'h20, 1, 0);
        tick();
        put(1, 16'h80, 16'h01, 0, 1);
        r_ordy = 1'b0;
        #1;
        chk("stall_in_ready", 32'(g_dut[0].d_irdy), 32'd0);
        chk0("stall_first", 1, e0[17], e0[16], e0[7:0]);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_in_ready_%0d", c), 32'(g_dut[0].d_irdy), 32'd0);
            chk0($sformatf("stall_frozen_%0d", c), 1, e0[17], e0[16], e0[7:0]);
        end
        r_ordy = 1'b1;
        tick();
        chk0("stall_second", 1, e1[17], e1[16], e1[7:0]);
        put(1, 16'h3C, 16'h3C, 1, 1);
        tick();
        chk0("stall_third", 1, e2[17], e2[16], e2[7:0]);
        put(0, 16'h0, 16'h0, 0, 0);
        repeat (6) tick();

        // Reset with the pipe full: two ops in flight must be discarded.
        r_ordy = 1'b0;
        put(1, 16'h11, 16'h22, 0, 0);
        tick();
        put(1, 16'h33, 16'h44, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk0("reset_full_outputs", 0, 0, 0, 8'h00);
        chk("reset_full_in_ready", 32'(g_dut[0].d_irdy), 32'd1);
        put(0, 16'h0, 16'h0, 0, 0);
        tick();
        rst_n  = 1'b1;
        r_ordy = 1'b1;
        put(1, 16'h10, 16'h20, 0, 0);
        tick();
        put(0, 16'h0, 16'h0, 0, 0);
        chk("post_reset_no_stale", 32'(g_dut[0].d_ovld), 32'd0);
        tick();
        chk0("post_reset_first", 1, 0, 0, 8'h30);
        repeat (4) tick();

        // Randomized stream with random valid / ready.
        for (int c = 0; c < 3000; c++) begin
            put($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom));
            r_ordy = ($urandom_range(0, 9) < 6);
            tick();
        end

        put(0, 16'h0, 16'h0, 0, 0);
        r_ordy = 1'b1;
        for (int c = 0; c < 200 && w_busy != '0; c++) tick();
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("u%0d_drained", k), 32'(w_busy[k]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
